// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM states, digit count and key decoding helpers for keypad_encoder
package keypad_pkg;
  typedef enum logic [1:0] {IDLE, DEBOUNCE, ACCEPT, RELEASE} state_t;
  localparam int NDIGITS = 4;
  function automatic logic [3:0] onehot_to_bcd(input logic [9:0] k);
    logic [3:0] b;
    b = '0;
    for (int i = 0; i < 10; i++) if (k[i]) b = 4'(i);
    return b;
  endfunction
  function automatic logic single_key(input logic [9:0] k);
    return $countones(k) == 1;
  endfunction
endpackage

// File: rtl/keypad_encoder_debounce_ctr.sv
// debounce_ctr: saturating sample counter shared by the press and release debounce phases
module debounce_ctr #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic done
);
  localparam int W = $clog2(N + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (inc && cnt != W'(N)) cnt <= cnt + 1'b1;
  // done means the sample being taken now is the Nth one
  assign done = cnt >= W'(N - 1);
endmodule

// File: rtl/keypad_encoder.sv
// keypad_encoder: debounced one-hot keypad to four-digit BCD MM:SS entry register
// Define KEYPAD_OVERFLOW_LOCK_EN to block further digits once the register is full.
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  teclado,
  input  logic        enable,
  input  logic        limpar,
  output logic [15:0] digitos,
  output logic [3:0]  tecla_bcd,
  output logic        valido,
  output logic        cheio,
  output logic        ocupado
);
  state_t state, nxt;
  logic [9:0] key;
  logic [2:0] cnt;
  logic clr, inc, done, hit, fire;
  debounce_ctr #(.N(DEBOUNCE_CYCLES)) u_ctr (
    .clk(clk), .rst(rst), .clr(clr), .inc(inc), .done(done)
  );
  always_comb begin
    hit = state == IDLE ? single_key(teclado) : teclado == key;
    nxt = state;
    clr = 1'b1;
    inc = 1'b0;
    if (!enable) nxt = IDLE;
    else
      case (state)
        IDLE, DEBOUNCE: begin
          nxt = !hit ? IDLE : done ? ACCEPT : DEBOUNCE;
          inc = hit && !done;
          clr = !inc;
        end
        ACCEPT: nxt = RELEASE;
        RELEASE: begin
          nxt = teclado == '0 && done ? IDLE : RELEASE;
          inc = teclado == '0 && !done;
          clr = !inc;
        end
        default: nxt = IDLE;
      endcase
  end
  assign cheio = cnt == 3'(NDIGITS);
  assign ocupado = state != IDLE;
`ifdef KEYPAD_OVERFLOW_LOCK_EN
  assign fire = enable && state == ACCEPT && !limpar && !cheio;
`else
  assign fire = enable && state == ACCEPT && !limpar;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      key <= '0;
      digitos <= '0;
      tecla_bcd <= '0;
      valido <= 1'b0;
      cnt <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE) key <= teclado;
      valido <= fire;
      if (limpar) begin
        digitos <= '0;
        cnt <= '0;
      end else if (fire) begin
        digitos <= {digitos[11:0], onehot_to_bcd(key)};
        tecla_bcd <= onehot_to_bcd(key);
        cnt <= cheio ? cnt : cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder: scoreboard bench for keypad_encoder (expected digits queued at press time)
module tb_keypad_encoder;
  localparam int N = 4;
`ifdef KEYPAD_OVERFLOW_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif
  logic clk = 0, rst = 1, enable = 1, limpar = 0;
  logic [9:0] teclado = '0;
  logic [15:0] digitos;
  logic [3:0] tecla_bcd;
  logic valido, cheio, ocupado;
  keypad_encoder #(.DEBOUNCE_CYCLES(N)) dut (
    .clk(clk), .rst(rst), .teclado(teclado), .enable(enable), .limpar(limpar),
    .digitos(digitos), .tecla_bcd(tecla_bcd), .valido(valido), .cheio(cheio), .ocupado(ocupado)
  );
  always #5 clk = ~clk;
  typedef struct {logic [3:0] bcd; logic [15:0] dig; int at;} exp_t;
  exp_t q[$];
  int cyc = 0, tests = 0, fails = 0;
  logic [15:0] mdig = '0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (valido) begin
      if (q.size() == 0) check("spurious_valido", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("tecla_bcd", tecla_bcd, e.bcd);
        check("digitos_at_valido", digitos, e.dig);
        check("latency", cyc, e.at);
      end
    end
  task automatic press(input int k, input int hold, input bit acc);
    @(negedge clk);
    teclado = 10'b1 << k;
    if (acc) begin
      mdig = {mdig[11:0], 4'(k)};
      q.push_back('{4'(k), mdig, cyc + 1 + N});
    end
    repeat (hold) @(negedge clk);
    teclado = '0;
    repeat (N + 2) @(negedge clk);
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_digitos"}, digitos, 0);
    check({tag, "_tecla"}, tecla_bcd, 0);
    check({tag, "_valido"}, valido, 0);
    check({tag, "_cheio"}, cheio, 0);
    check({tag, "_ocupado"}, ocupado, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 0;
    press(7, 10, 1);
    check("key7_digitos", digitos, 16'h0007);
    press(3, 3, 0);
    press(3, 6, 1);
    check("key3_digitos", digitos, mdig);
    @(negedge clk);
    teclado = 10'h006;
    repeat (20) @(negedge clk);
    check("multi_ocupado", ocupado, 0);
    teclado = '0;
    check("multi_digitos", digitos, mdig);
    limpar = 1;
    @(negedge clk);
    limpar = 0;
    mdig = '0;
    check("clear_digitos", digitos, 0);
    check("clear_cheio", cheio, 0);
    press(1, 5, 1);
    press(2, 5, 1);
    press(3, 5, 1);
    check("three_cheio", cheio, 0);
    press(0, 5, 1);
    check("full_digitos", digitos, 16'h1230);
    check("full_cheio", cheio, 1);
    press(5, 6, !LOCK);
    check("fifth_digitos", digitos, LOCK ? 16'h1230 : 16'h2305);
    check("fifth_cheio", cheio, 1);
    @(negedge clk);
    teclado = 10'b1 << 9;
    repeat (N) @(negedge clk);
    limpar = 1;
    @(negedge clk);
    limpar = 0;
    mdig = '0;
    check("clr_accept_digitos", digitos, 0);
    check("clr_accept_cheio", cheio, 0);
    check("clr_accept_release", ocupado, 1);
    repeat (8) @(negedge clk);
    teclado = '0;
    repeat (N + 2) @(negedge clk);
    check("clr_accept_idle", ocupado, 0);
    check("clr_accept_no_digit", digitos, 0);
    @(negedge clk);
    teclado = 10'b1 << 4;
    repeat (2) @(negedge clk);
    check("debounce_busy", ocupado, 1);
    enable = 0;
    @(negedge clk);
    check("enable_low_idle", ocupado, 0);
    repeat (10) @(negedge clk);
    teclado = '0;
    enable = 1;
    repeat (N + 2) @(negedge clk);
    check("enable_digitos", digitos, 0);
    @(negedge clk);
    teclado = 10'b1 << 6;
    mdig = {mdig[11:0], 4'd6};
    q.push_back('{4'd6, mdig, cyc + 1 + N});
    repeat (N + 2) @(negedge clk);
    check("release_busy", ocupado, 1);
    check("release_digitos", digitos, 16'h0006);
    rst = 1;
    teclado = '0;
    @(negedge clk);
    rst = 0;
    check_reset("midrst");
    repeat (N + 4) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end
endmodule
